tdm_demux8: RTL and testbench
=============================

# tdm_demux8

Receive-side 1-to-8 time-division demultiplexer: the counterpart of the team's 8:1 select-line multiplexer when that multiplexer is driven by a slot counter to serialise eight channels onto one wire. It takes a serial stream with a frame-start marker, locks onto frame boundaries and routes each slot's bit to its channel. It presents all eight channel bits together as one registered word per frame, with loss-of-lock and misplaced-sync reporting.

## Interface
- MISS_LIMIT, 2: consecutive missing sync markers at slot 0 (while locked) that drop lock; legal range 1–7.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- din  input  1  serial data bit for the current slot
- en  input  1  din/sync valid this cycle; nothing advances when low
- sync  input  1  frame marker, high with the slot-0 bit; ignored when en=0
- q  output  8  last complete frame; q[s] = bit received in slot s (slot s = transmitter select value, bit 2 MSB)
- sel  output  3  slot index the next accepted bit is written to
- frame_valid  output  1  one-cycle pulse: q was just updated
- locked  output  1  high while frame alignment is held
- sync_err  output  1  one-cycle pulse: sync seen at slot ≠ 0 while locked

## Operation
- Reset (async, rst_n=0): q=8'h00, sel=0, frame_valid=0, sync_err=0, locked=0, state HUNT, miss_cnt=0, shadow=0. Takes effect immediately, mid-frame included; the partial frame is discarded.
- Two states: HUNT, LOCKED. locked = (state==LOCKED), registered.
- The "accepted bit" is en=1 at a rising edge. Cycles with en=0 hold all state. frame_valid and sync_err are 0 in the cycle after any en=0 edge.
- HUNT:
  - en=1, sync=0: bit dropped; sel stays 0.
  - en=1, sync=1: shadow[0]<=din, sel<=1, miss_cnt<=0, state<=LOCKED.
- LOCKED, accepted bit at sel=s:
  - s in 1..6, sync=0: shadow[s]<=din, sel<=s+1.
  - s=7, sync=0: q<={din, shadow[6:0]}, frame_valid<=1, sel<=0 (wrap).
  - s≠0, sync=1 (misplaced): sync_err<=1. Partial frame discarded with no frame_valid. Realign with shadow[0]<=din, sel<=1, miss_cnt<=0.
  - s=0, sync=1: shadow[0]<=din, sel<=1, miss_cnt<=0.
  - s=0, sync=0 (missing marker): miss_cnt<=miss_cnt+1.
    - If the new count < MISS_LIMIT: flywheel; shadow[0]<=din, sel<=1.
    - If the new count == MISS_LIMIT: state<=HUNT, sel<=0, miss_cnt<=0; bit dropped.
- q changes only on a complete slot 0–7 frame. It holds its value across HUNT, loss of lock and sync_err.
- miss_cnt is 3 bits. It resets to 0 on every correctly placed or realigning sync.

## Timing
- All outputs are registered from clk (no combinational input→output paths).
- Latency: the slot-7 bit appears on q[7], and q updates, at the same edge that accepts it. frame_valid is high for exactly the following cycle.
- Back-to-back frames with en held high give one frame_valid every 8 cycles, and q is stable for 8 cycles between updates.
- Sync at slot 7 while locked is misplaced. That bit goes to shadow[0], no frame_valid, sync_err=1 next cycle.
- The first frame after HUNT→LOCKED produces frame_valid 7 accepted bits after the sync bit.
- After rst_n rises, the first edge with en=1 is processed normally in HUNT.

## Test plan
- Reset then frames: rst_n low mid-stream gives q=00, sel=0, locked=0 immediately. Then 8 bits with sync on the first, din=1,0,1,1,0,0,1,0 (slot 0..7): q=8'h4D, a single frame_valid pulse one cycle after the slot-7 edge, locked=1 from the edge after the sync.
- en gaps: same frame with en=0 for 3 cycles inserted after slot 3. q=8'h4D and frame_valid are delayed by 3 cycles; sel holds 4 during the gap.
- Misplaced sync: locked, sync asserted at slot 5. sync_err pulses one cycle, no frame_valid, sel=1 next. The following 7 bits complete a frame and q updates once.
- Flywheel and loss of lock (MISS_LIMIT=2): first slot-0 arrives without sync, frame still decodes with frame_valid. Second consecutive slot-0 without sync gives locked=0, sel=0, bit dropped, q unchanged.
- Hunt filtering: 20 accepted bits with sync=0 after reset give locked=0, sel=0, no frame_valid, q=00.
- Reset mid-frame: rst_n pulsed low at slot 4 gives async clear of outputs. No frame_valid for the aborted frame; the next sync-led frame decodes correctly.

Source files
------------

// File: rtl/tdm_demux8.sv
// ============================================================================
// tdm_demux8 : 1-to-8 TDM receiver; locks on slot-0 sync, emits one word/frame
// Revision   : 1.0  initial release
// ============================================================================
`default_nettype none

module tdm_demux8 #(
   parameter int MISS_LIMIT = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       din,
   input  logic       en,
   input  logic       sync,
   output logic [7:0] q,
   output logic [2:0] sel,
   output logic       frame_valid,
   output logic       locked,
   output logic       sync_err
);

   typedef enum logic [0:0] {
      ST_HUNT   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   localparam logic [2:0] c_miss_limit = 3'(MISS_LIMIT);

   state_t     state_q, state_d;
   logic [2:0] sel_q, sel_d;
   logic [2:0] miss_q, miss_d;
   logic [6:0] shadow_q, shadow_d;
   logic [7:0] data_q, data_d;
   logic       fv_q, fv_d;
   logic       serr_q, serr_d;
   logic [2:0] miss_inc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_HUNT;
         sel_q    <= 3'd0;
         miss_q   <= 3'd0;
         shadow_q <= 7'd0;
         data_q   <= 8'd0;
         fv_q     <= 1'b0;
         serr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         miss_q   <= miss_d;
         shadow_q <= shadow_d;
         data_q   <= data_d;
         fv_q     <= fv_d;
         serr_q   <= serr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      miss_d   = miss_q;
      shadow_d = shadow_q;
      data_d   = data_q;
      fv_d     = 1'b0;
      serr_d   = 1'b0;
      miss_inc = miss_q + 3'd1;

      if (en) begin
         case (state_q)
            ST_HUNT: begin
               if (sync) begin
                  shadow_d[0] = din;
                  sel_d       = 3'd1;
                  miss_d      = 3'd0;
                  state_d     = ST_LOCKED;
               end
            end
            ST_LOCKED: begin
               if (sync) begin
                  // A sync anywhere but slot 0 discards the partial frame and realigns.
                  serr_d      = (sel_q != 3'd0);
                  shadow_d[0] = din;
                  sel_d       = 3'd1;
                  miss_d      = 3'd0;
               end else if (sel_q == 3'd0) begin
                  if (miss_inc < c_miss_limit) begin
                     miss_d      = miss_inc;
                     shadow_d[0] = din;
                     sel_d       = 3'd1;
                  end else begin
                     state_d = ST_HUNT;
                     sel_d   = 3'd0;
                     miss_d  = 3'd0;
                  end
               end else if (sel_q == 3'd7) begin
                  data_d = {din, shadow_q};
                  fv_d   = 1'b1;
                  sel_d  = 3'd0;
               end else begin
                  for (int i = 1; i < 7; i++) begin
                     if (sel_q == 3'(i)) shadow_d[i] = din;
                  end
                  sel_d = sel_q + 3'd1;
               end
            end
            default: state_d = ST_HUNT;
         endcase
      end
   end

   assign q           = data_q;
   assign sel         = sel_q;
   assign frame_valid = fv_q;
   assign locked      = (state_q == ST_LOCKED);
   assign sync_err    = serr_q;

endmodule

`default_nettype wire

// File: tb/tb_tdm_demux8.sv
// ============================================================================
// tb_tdm_demux8 : vector table, corner sequences and randomized model check
// Revision      : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tdm_demux8;

   localparam int MISS_LIMIT = 2;

   logic       clk;
   logic       rst_n;
   logic       din;
   logic       en;
   logic       sync;
   logic [7:0] q;
   logic [2:0] sel;
   logic       frame_valid;
   logic       locked;
   logic       sync_err;

   int n_tests;
   int n_fail;

   tdm_demux8 #(.MISS_LIMIT(MISS_LIMIT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .din         (din),
      .en          (en),
      .sync        (sync),
      .q           (q),
      .sel         (sel),
      .frame_valid (frame_valid),
      .locked      (locked),
      .sync_err    (sync_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       en;
      logic       sync;
      logic       din;
      logic [7:0] q;
      logic [2:0] sel;
      logic       fv;
      logic       lk;
      logic       se;
   } vec_t;

   vec_t vecs[$];

   // Reference receiver: slot index and frame bits kept as plain ints/arrays.
   bit       m_locked;
   int       m_slot;
   int       m_miss;
   bit [7:0] m_bits;
   bit [7:0] m_q;
   bit       m_fv;
   bit       m_se;

   function automatic logic [13:0] pack(logic [7:0] pq, logic [2:0] ps, logic pf,
                                        logic pl, logic pe);
      return {pq, ps, pf, pl, pe};
   endfunction

   task automatic chk(string name, logic [13:0] got, logic [13:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got q=%h sel=%0d fv=%b lk=%b se=%b, expected q=%h sel=%0d fv=%b lk=%b se=%b",
                  name, got[13:6], got[5:3], got[2], got[1], got[0],
                  exp[13:6], exp[5:3], exp[2], exp[1], exp[0]);
      end
   endtask

   function automatic logic [13:0] dut_out();
      return pack(q, sel, frame_valid, locked, sync_err);
   endfunction

   task automatic cyc(logic e, logic s, logic d);
      @(negedge clk);
      en   = e;
      sync = s;
      din  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic add(logic e, logic s, logic d, logic [7:0] eq, logic [2:0] es,
                      logic ef, logic el, logic ee);
      vec_t v;
      v.en = e; v.sync = s; v.din = d; v.q = eq; v.sel = es;
      v.fv = ef; v.lk = el; v.se = ee;
      vecs.push_back(v);
   endtask

   task automatic add_frame_bits(logic [7:0] bits, logic [7:0] qprev, logic [7:0] qnew,
                                 int start_slot);
      for (int s = start_slot; s < 8; s++) begin
         if (s == 7) add(1, 0, bits[s], qnew, 3'd0, 1, 1, 0);
         else        add(1, 0, bits[s], qprev, 3'(s + 1), 0, 1, 0);
      end
   endtask

   task automatic model_reset();
      m_locked = 0; m_slot = 0; m_miss = 0; m_bits = '0; m_q = '0; m_fv = 0; m_se = 0;
   endtask

   task automatic model_step(bit e, bit s, bit d);
      m_fv = 0;
      m_se = 0;
      if (!e) return;
      if (!m_locked) begin
         if (s) begin
            m_locked = 1; m_bits[0] = d; m_slot = 1; m_miss = 0;
         end
      end else if (s) begin
         m_se = (m_slot != 0);
         m_bits[0] = d; m_slot = 1; m_miss = 0;
      end else if (m_slot == 0) begin
         m_miss = m_miss + 1;
         if (m_miss >= MISS_LIMIT) begin
            m_locked = 0; m_slot = 0; m_miss = 0;
         end else begin
            m_bits[0] = d; m_slot = 1;
         end
      end else begin
         m_bits[m_slot] = d;
         if (m_slot == 7) begin
            m_q = m_bits; m_fv = 1; m_slot = 0;
         end else begin
            m_slot = m_slot + 1;
         end
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n = 1'b0; en = 1'b0; sync = 1'b0; din = 1'b0;

      // Frame 1 = slots 0..7 {1,0,1,1,0,0,1,0} -> 8'h4D
      add(1, 1, 1, 8'h00, 3'd1, 0, 1, 0);
      add_frame_bits(8'b0100_1101, 8'h00, 8'h4D, 1);
      add(0, 0, 0, 8'h4D, 3'd0, 0, 1, 0);
      // Same frame with a 3-cycle en gap after slot 3
      add(1, 1, 1, 8'h4D, 3'd1, 0, 1, 0);
      add(1, 0, 0, 8'h4D, 3'd2, 0, 1, 0);
      add(1, 0, 1, 8'h4D, 3'd3, 0, 1, 0);
      add(1, 0, 1, 8'h4D, 3'd4, 0, 1, 0);
      for (int i = 0; i < 3; i++) add(0, 1, 1, 8'h4D, 3'd4, 0, 1, 0);
      add_frame_bits(8'b0100_1101, 8'h4D, 8'h4D, 4);
      // Misplaced sync at slot 5, then 7 bits complete a realigned frame of ones
      add(1, 1, 0, 8'h4D, 3'd1, 0, 1, 0);
      for (int s = 1; s < 5; s++) add(1, 0, 1, 8'h4D, 3'(s + 1), 0, 1, 0);
      add(1, 1, 1, 8'h4D, 3'd1, 0, 1, 1);
      add_frame_bits(8'hFF, 8'h4D, 8'hFF, 1);
      // Flywheel: missing sync once still decodes, twice drops lock
      add(1, 0, 1, 8'hFF, 3'd1, 0, 1, 0);
      add_frame_bits(8'h55, 8'hFF, 8'h55, 1);
      add(1, 0, 1, 8'h55, 3'd0, 0, 0, 0);
      add(1, 0, 1, 8'h55, 3'd0, 0, 0, 0);

      #12;
      chk("reset_async", dut_out(), pack(8'h00, 3'd0, 0, 0, 0));
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 20; i++) begin
         cyc(1, 0, 1'($urandom));
         chk($sformatf("hunt_filter_%0d", i), dut_out(), pack(8'h00, 3'd0, 0, 0, 0));
      end

      foreach (vecs[i]) begin
         cyc(vecs[i].en, vecs[i].sync, vecs[i].din);
         chk($sformatf("vec_%0d", i), dut_out(),
             pack(vecs[i].q, vecs[i].sel, vecs[i].fv, vecs[i].lk, vecs[i].se));
      end

      // Reset mid-frame at slot 4 discards the partial frame
      cyc(1, 1, 1);
      for (int s = 1; s < 4; s++) cyc(1, 0, 1);
      chk("pre_reset_sel", dut_out(), pack(8'h55, 3'd4, 0, 1, 0));
      rst_n = 1'b0;
      #1;
      chk("midframe_reset", dut_out(), pack(8'h00, 3'd0, 0, 0, 0));
      @(negedge clk);
      rst_n = 1'b1;
      cyc(1, 0, 1);
      chk("post_reset_hunt", dut_out(), pack(8'h00, 3'd0, 0, 0, 0));
      begin
         logic [7:0] pat;
         pat = 8'hA6;
         cyc(1, 1, pat[0]);
         for (int s = 1; s < 8; s++) cyc(1, 0, pat[s]);
         chk("post_reset_frame", dut_out(), pack(8'hA6, 3'd0, 1, 1, 0));
      end

      // Randomized stream against the reference model
      rst_n = 1'b0;
      #1;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      begin
         int  tx_slot;
         logic e, s, d;
         tx_slot = 0;
         for (int i = 0; i < 3000; i++) begin
            e = ($urandom_range(0, 9) != 0);
            d = 1'($urandom);
            s = 1'b0;
            if (e) begin
               if (tx_slot == 0) s = ($urandom_range(0, 9) != 0);
               else              s = ($urandom_range(0, 39) == 0);
               tx_slot = (tx_slot + 1) % 8;
               if ($urandom_range(0, 99) == 0) tx_slot = $urandom_range(0, 7);
            end
            cyc(e, s, d);
            model_step(e, s, d);
            chk($sformatf("rand_%0d", i), dut_out(),
                pack(m_q, 3'(m_slot), m_fv, m_locked, m_se));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
